// File: rtl/ahb_slave_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ahb_slave_arbiter_pkg
//   Shared types for the per-slave arbiter: the AHB transfer type encoding,
//   the arbiter FSM state type, and two small helpers that classify a transfer.
// ----------------------------------------------------------------------------
package ahb_slave_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_OWNED = 1'b1
    } arb_state_type;

    // IDLE and NONSEQ are the only address phases at which the owner may be
    // replaced; SEQ and BUSY are always in the middle of a burst.
    function automatic logic trans_allows_switch(htrans_type t);
        return (t == IDLE) || (t == NONSEQ);
    endfunction

    // Address phases that are followed by a real data phase.
    function automatic logic trans_has_data(htrans_type t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_arbiter_if
//   Bundle of the request/grant signals between the masters' decoders and the
//   arbiter that sits in front of one slave.
//   hreq         per-master request for this slave
//   htrans       per-master transfer type
//   hready_slv   slave HREADYOUT, a transfer is accepted when 1
//   hgrant       one-hot grant (registered)
//   hsel_slv     slave select, combinational
//   hmaster_addr address-phase owner index
//   hmaster_data data-phase owner index
//   hdata_valid  the current data phase belongs to a selected transfer
//   Modport master: request side. Modport slave: the arbiter itself.
// ----------------------------------------------------------------------------
interface ahb_slave_arbiter_if
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int SLAVE_X_MASTER_NUM = 3
);
    localparam int IDX_W = $clog2(SLAVE_X_MASTER_NUM);

    logic [SLAVE_X_MASTER_NUM-1:0] hreq;
    htrans_type                    htrans [SLAVE_X_MASTER_NUM];
    logic                          hready_slv;
    logic [SLAVE_X_MASTER_NUM-1:0] hgrant;
    logic                          hsel_slv;
    logic [IDX_W-1:0]              hmaster_addr;
    logic [IDX_W-1:0]              hmaster_data;
    logic                          hdata_valid;

    modport master (
        output hreq, htrans, hready_slv,
        input  hgrant, hsel_slv, hmaster_addr, hmaster_data, hdata_valid
    );

    modport slave (
        input  hreq, htrans, hready_slv,
        output hgrant, hsel_slv, hmaster_addr, hmaster_data, hdata_valid
    );

endinterface

// File: rtl/ahb_slave_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// ahb_rr_pick
//   Combinational rotate-priority encoder. Finds the first set bit of req
//   scanning upward from (ptr+1) mod N and wrapping, so ptr itself is checked
//   last.
//   req    in  N        request vector
//   ptr    in  IDX_W    index of the most recent winner
//   found  out 1        at least one request bit is set
//   idx    out IDX_W    index of the winning request
// ----------------------------------------------------------------------------
module ahb_rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] cand;

    // Walk the rotation backwards so that the last hit written is the first
    // one in rotation order.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_slave_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_slave_arbiter
//   Round-robin arbiter for one AHB slave. Grants the slave to one requesting
//   master, holds the grant across bursts, limits back-to-back NONSEQ ownership
//   while others wait, and tracks which master owns the current data phase.
//   hclk      in  system clock
//   hreset_n  in  asynchronous active-low reset
//   bus       slave modport of ahb_slave_arbiter_if (requests in, grant out)
// ----------------------------------------------------------------------------
module ahb_slave_arbiter
    import ahb_slave_arbiter_pkg::*;
#(
    parameter int SLAVE_X_MASTER_NUM = 3,
    parameter int MAX_HOLD           = 4
) (
    input  logic                hclk,
    input  logic                hreset_n,
    ahb_slave_arbiter_if.slave  bus
);
    localparam int N      = SLAVE_X_MASTER_NUM;
    localparam int IDX_W  = $clog2(N);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N - 1);

    arb_state_type    state_q, state_d;
    logic [N-1:0]     hgrant_q, hgrant_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0] data_q, data_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic             dvalid_q, dvalid_d;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             owned, owner_req, others_req, hsel, arb_point, keep_owner;
    htrans_type       owner_trans;

    ahb_rr_pick #(.N(N)) u_pick (
        .req   (bus.hreq),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // The owner index is only meaningful while owned; when idle the grant is
    // zero so hsel and the owner terms collapse to 0.
    always_comb begin
        owned       = (state_q == ARB_OWNED);
        owner_req   = owned & bus.hreq[addr_q];
        owner_trans = bus.htrans[addr_q];
        others_req  = |(bus.hreq & ~hgrant_q);
        hsel        = |(hgrant_q & bus.hreq);
        arb_point   = !owned || !owner_req || trans_allows_switch(owner_trans);
        keep_owner  = owner_req && (owner_trans == NONSEQ) &&
                      (!others_req || (int'(hold_q) < MAX_HOLD - 1));
    end

    // Next-state logic. Everything freezes while the slave stalls; the hold
    // counter only advances when the owner is kept at someone else's expense.
    always_comb begin
        state_d  = state_q;
        hgrant_d = hgrant_q;
        addr_d   = addr_q;
        data_d   = data_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        dvalid_d = dvalid_q;
        if (bus.hready_slv) begin
            data_d   = addr_q;
            dvalid_d = hsel && trans_has_data(owner_trans);
            if (arb_point) begin
                if (keep_owner) begin
                    if (others_req) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (pick_found) begin
                    state_d  = ARB_OWNED;
                    hgrant_d = N'(1) << pick_idx;
                    addr_d   = pick_idx;
                    ptr_d    = pick_idx;
                    hold_d   = '0;
                end else begin
                    state_d  = ARB_IDLE;
                    hgrant_d = '0;
                end
            end
        end
    end

    // Reset pointer sits on the last master so master 0 wins the first round.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q  <= ARB_IDLE;
            hgrant_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ptr_q    <= PTR_RESET;
            hold_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hgrant_q <= hgrant_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign bus.hgrant       = hgrant_q;
    assign bus.hsel_slv     = hsel;
    assign bus.hmaster_addr = addr_q;
    assign bus.hmaster_data = data_q;
    assign bus.hdata_valid  = dvalid_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_arbiter
//   Drives two arbiters (MAX_HOLD=4 and MAX_HOLD=1) from the same request
//   inputs. Directed vectors, hand-written reset/burst sequences and a
//   randomized run against a behavioural model of the arbitration rules.
// ----------------------------------------------------------------------------
module tb_ahb_slave_arbiter;
    import ahb_slave_arbiter_pkg::*;

    localparam int N = 3;

    logic       hclk = 1'b0;
    logic       hreset_n;
    logic [N-1:0] req;
    htrans_type trans [N];
    logic       rdy;

    int checks = 0;
    int passes = 0;

    always #5 hclk = ~hclk;

    ahb_slave_arbiter_if #(.SLAVE_X_MASTER_NUM(N)) ifa ();
    ahb_slave_arbiter_if #(.SLAVE_X_MASTER_NUM(N)) ifb ();

    assign ifa.hreq       = req;
    assign ifa.htrans     = trans;
    assign ifa.hready_slv = rdy;
    assign ifb.hreq       = req;
    assign ifb.htrans     = trans;
    assign ifb.hready_slv = rdy;

    ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(N), .MAX_HOLD(4)) dut_a (
        .hclk(hclk), .hreset_n(hreset_n), .bus(ifa.slave)
    );

    ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(N), .MAX_HOLD(1)) dut_b (
        .hclk(hclk), .hreset_n(hreset_n), .bus(ifb.slave)
    );

    typedef struct {
        logic [2:0] req;
        htrans_type t0, t1, t2;
        logic       rdy;
        logic [2:0] grant;
        logic [1:0] maddr;
        logic [1:0] mdata;
        logic       dvalid;
        logic       hsel;
    } vec_t;

    // Behavioural model state: owner -1 means nobody holds the slave.
    typedef struct {
        int owner;
        int ptr;
        int hold;
        int maddr;
        int mdata;
        int dvalid;
    } mdl_t;

    vec_t vecs [19];
    mdl_t ma, mb;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passes++;
    endtask

    // Drive one set of inputs, let one rising edge happen, return at negedge.
    task automatic applyStimulus(input logic [2:0] r, input htrans_type t0, input htrans_type t1,
                                 input htrans_type t2, input logic rd);
        req = r;
        trans[0] = t0;
        trans[1] = t1;
        trans[2] = t2;
        rdy = rd;
        @(posedge hclk);
        @(negedge hclk);
    endtask

    task automatic doReset();
        hreset_n = 1'b0;
        req = '0;
        trans[0] = IDLE;
        trans[1] = IDLE;
        trans[2] = IDLE;
        rdy = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        hreset_n = 1'b1;
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.owner = -1;
        s.ptr = N - 1;
        s.hold = 0;
        s.maddr = 0;
        s.mdata = 0;
        s.dvalid = 0;
        return s;
    endfunction

    function automatic bit mdl_hsel(mdl_t s);
        if (s.owner < 0) return 1'b0;
        return req[s.owner];
    endfunction

    function automatic int mdl_grant(mdl_t s);
        if (s.owner < 0) return 0;
        return 1 << s.owner;
    endfunction

    // One accepted edge of the arbitration rules, from the current inputs.
    function automatic mdl_t mdl_step(mdl_t s, int maxhold);
        mdl_t n = s;
        bit   sel, others, ap, keep;
        if (!rdy) return s;
        sel = mdl_hsel(s);
        n.mdata = s.maddr;
        n.dvalid = 0;
        if (sel && (trans[s.owner] == NONSEQ || trans[s.owner] == SEQ)) n.dvalid = 1;
        others = 0;
        for (int j = 0; j < N; j++)
            if (j != s.owner && req[j]) others = 1;
        ap = 1;
        keep = 0;
        if (s.owner >= 0 && req[s.owner]) begin
            ap = (trans[s.owner] == IDLE || trans[s.owner] == NONSEQ);
            keep = (trans[s.owner] == NONSEQ) && (!others || s.hold < maxhold - 1);
        end
        if (ap) begin
            if (keep) begin
                if (others) n.hold = s.hold + 1;
            end else begin
                n.owner = -1;
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (s.ptr + k) % N;
                    if (n.owner < 0 && req[c]) begin
                        n.owner = c;
                        n.ptr = c;
                        n.maddr = c;
                        n.hold = 0;
                    end
                end
            end
        end
        return n;
    endfunction

    initial begin
        logic [2:0] exp_a [5];
        logic [2:0] exp_b [5];
        htrans_type tr [4];

        // ---------------- reset with everyone requesting ----------------
        hreset_n = 1'b0;
        req = 3'b111;
        trans[0] = NONSEQ;
        trans[1] = NONSEQ;
        trans[2] = NONSEQ;
        rdy = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        checkOutput("rst a.grant", 32'(ifa.hgrant), 32'h0);
        checkOutput("rst a.hsel", 32'(ifa.hsel_slv), 32'h0);
        checkOutput("rst a.dvalid", 32'(ifa.hdata_valid), 32'h0);
        checkOutput("rst a.maddr", 32'(ifa.hmaster_addr), 32'h0);
        checkOutput("rst a.mdata", 32'(ifa.hmaster_data), 32'h0);
        checkOutput("rst b.grant", 32'(ifb.hgrant), 32'h0);
        checkOutput("rst b.hsel", 32'(ifb.hsel_slv), 32'h0);
        checkOutput("rst b.dvalid", 32'(ifb.hdata_valid), 32'h0);
        hreset_n = 1'b1;
        applyStimulus(3'b111, NONSEQ, NONSEQ, NONSEQ, 1'b1);
        checkOutput("rst first a.grant", 32'(ifa.hgrant), 32'h1);
        checkOutput("rst first b.grant", 32'(ifb.hgrant), 32'h1);

        // ---------------- directed vectors on the MAX_HOLD=4 arbiter -----
        vecs[0]  = '{3'b010, IDLE,   NONSEQ, IDLE,   1'b1, 3'b010, 2'd1, 2'd0, 1'b0, 1'b1};
        vecs[1]  = '{3'b010, IDLE,   NONSEQ, IDLE,   1'b1, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1};
        vecs[2]  = '{3'b000, IDLE,   IDLE,   IDLE,   1'b1, 3'b000, 2'd1, 2'd1, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, NONSEQ, NONSEQ, IDLE,   1'b1, 3'b001, 2'd0, 2'd1, 1'b0, 1'b1};
        vecs[4]  = '{3'b011, NONSEQ, NONSEQ, IDLE,   1'b1, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[5]  = '{3'b011, NONSEQ, NONSEQ, IDLE,   1'b1, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[6]  = '{3'b011, NONSEQ, NONSEQ, IDLE,   1'b1, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[7]  = '{3'b011, NONSEQ, NONSEQ, IDLE,   1'b1, 3'b010, 2'd1, 2'd0, 1'b1, 1'b1};
        vecs[8]  = '{3'b010, IDLE,   NONSEQ, IDLE,   1'b1, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1};
        vecs[9]  = '{3'b011, NONSEQ, IDLE,   IDLE,   1'b0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1};
        vecs[10] = '{3'b011, NONSEQ, IDLE,   IDLE,   1'b0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1};
        vecs[11] = '{3'b011, NONSEQ, IDLE,   IDLE,   1'b0, 3'b010, 2'd1, 2'd1, 1'b1, 1'b1};
        vecs[12] = '{3'b011, NONSEQ, IDLE,   IDLE,   1'b1, 3'b001, 2'd0, 2'd1, 1'b0, 1'b1};
        vecs[13] = '{3'b101, NONSEQ, IDLE,   NONSEQ, 1'b1, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[14] = '{3'b101, SEQ,    IDLE,   NONSEQ, 1'b1, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[15] = '{3'b101, SEQ,    IDLE,   NONSEQ, 1'b1, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[16] = '{3'b101, SEQ,    IDLE,   NONSEQ, 1'b1, 3'b001, 2'd0, 2'd0, 1'b1, 1'b1};
        vecs[17] = '{3'b100, IDLE,   IDLE,   NONSEQ, 1'b1, 3'b100, 2'd2, 2'd0, 1'b0, 1'b1};
        vecs[18] = '{3'b000, IDLE,   IDLE,   IDLE,   1'b1, 3'b000, 2'd2, 2'd2, 1'b0, 1'b0};

        doReset();
        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].req, vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].rdy);
            checkOutput($sformatf("vec[%0d] grant", i), 32'(ifa.hgrant), 32'(vecs[i].grant));
            checkOutput($sformatf("vec[%0d] maddr", i), 32'(ifa.hmaster_addr), 32'(vecs[i].maddr));
            checkOutput($sformatf("vec[%0d] mdata", i), 32'(ifa.hmaster_data), 32'(vecs[i].mdata));
            checkOutput($sformatf("vec[%0d] dvalid", i), 32'(ifa.hdata_valid), 32'(vecs[i].dvalid));
            checkOutput($sformatf("vec[%0d] hsel", i), 32'(ifa.hsel_slv), 32'(vecs[i].hsel));
        end

        // ---------------- all three masters issuing single NONSEQs -------
        exp_a = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
        exp_b = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b111, NONSEQ, NONSEQ, NONSEQ, 1'b1);
            checkOutput($sformatf("rot[%0d] a.grant", i), 32'(ifa.hgrant), 32'(exp_a[i]));
            checkOutput($sformatf("rot[%0d] b.grant", i), 32'(ifb.hgrant), 32'(exp_b[i]));
        end

        // ---------------- reset in the middle of an INCR4 ----------------
        doReset();
        applyStimulus(3'b001, NONSEQ, IDLE, IDLE, 1'b1);
        checkOutput("mid a.grant owned", 32'(ifa.hgrant), 32'h1);
        tr = '{NONSEQ, SEQ, SEQ, SEQ};
        applyStimulus(3'b101, tr[1], IDLE, NONSEQ, 1'b1);
        checkOutput("mid a.grant burst", 32'(ifa.hgrant), 32'h1);
        #2 hreset_n = 1'b0;
        #1;
        checkOutput("mid rst a.grant", 32'(ifa.hgrant), 32'h0);
        checkOutput("mid rst a.hsel", 32'(ifa.hsel_slv), 32'h0);
        checkOutput("mid rst a.dvalid", 32'(ifa.hdata_valid), 32'h0);
        @(negedge hclk);
        hreset_n = 1'b1;
        applyStimulus(3'b101, NONSEQ, IDLE, NONSEQ, 1'b1);
        checkOutput("post rst a.grant", 32'(ifa.hgrant), 32'h1);
        checkOutput("post rst a.maddr", 32'(ifa.hmaster_addr), 32'h0);

        // ---------------- randomized run against the model ---------------
        doReset();
        ma = mdl_reset();
        mb = mdl_reset();
        for (int i = 0; i < 300; i++) begin
            req = 3'($urandom_range(0, 7));
            for (int m = 0; m < N; m++) trans[m] = htrans_type'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 3) != 0);
            ma = mdl_step(ma, 4);
            mb = mdl_step(mb, 1);
            @(posedge hclk);
            @(negedge hclk);
            checkOutput($sformatf("rand[%0d] a.grant", i), 32'(ifa.hgrant), 32'(mdl_grant(ma)));
            checkOutput($sformatf("rand[%0d] a.hsel", i), 32'(ifa.hsel_slv), 32'(mdl_hsel(ma)));
            checkOutput($sformatf("rand[%0d] a.maddr", i), 32'(ifa.hmaster_addr), 32'(ma.maddr));
            checkOutput($sformatf("rand[%0d] a.mdata", i), 32'(ifa.hmaster_data), 32'(ma.mdata));
            checkOutput($sformatf("rand[%0d] a.dvalid", i), 32'(ifa.hdata_valid), 32'(ma.dvalid));
            checkOutput($sformatf("rand[%0d] b.grant", i), 32'(ifb.hgrant), 32'(mdl_grant(mb)));
            checkOutput($sformatf("rand[%0d] b.hsel", i), 32'(ifb.hsel_slv), 32'(mdl_hsel(mb)));
            checkOutput($sformatf("rand[%0d] b.maddr", i), 32'(ifb.hmaster_addr), 32'(mb.maddr));
            checkOutput($sformatf("rand[%0d] b.mdata", i), 32'(ifb.hmaster_data), 32'(mb.mdata));
            checkOutput($sformatf("rand[%0d] b.dvalid", i), 32'(ifb.hdata_valid), 32'(mb.dvalid));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
